// File: rtl/display_pkg.sv
// Shared constants and helpers for the pixel compositor: palette indices,
// reset palette colours and the cell-border test.
package display_pkg;

    localparam logic [1:0] PAL_BG     = 2'd0;
    localparam logic [1:0] PAL_GRID   = 2'd1;
    localparam logic [1:0] PAL_FG     = 2'd2;
    localparam logic [1:0] PAL_CURSOR = 2'd3;

    localparam int PAL_N       = 4;
    localparam int MAX_COLOR_W = 48;

    // Widths divisible by 3 are treated as RGB with equal channels; any other
    // width is a single grey channel.
    function automatic logic [MAX_COLOR_W-1:0] default_color(input int color_w,
                                                             input logic [1:0] idx);
        int                     ch_w;
        int                     n_ch;
        logic [MAX_COLOR_W-1:0] full;
        logic [MAX_COLOR_W-1:0] ch;
        logic [MAX_COLOR_W-1:0] res;
        ch_w = (color_w % 3 == 0) ? color_w / 3 : color_w;
        n_ch = (color_w % 3 == 0) ? 3 : 1;
        full = (MAX_COLOR_W'(1) << ch_w) - MAX_COLOR_W'(1);
        case (idx)
            PAL_BG:   ch = '0;
            PAL_GRID: ch = full / MAX_COLOR_W'(5);
            PAL_FG:   ch = full;
            default:  ch = (full / MAX_COLOR_W'(5)) * MAX_COLOR_W'(4);
        endcase
        res = '0;
        for (int i = 0; i < 3; i++) begin
            if (i < n_ch) res = res | (ch << (i * ch_w));
        end
        return res;
    endfunction

    // A pixel is on a cell border when its in-cell offset on either axis is
    // the first or last position of the cell.
    function automatic logic is_border(input logic [31:0] h, input logic [31:0] v,
                                       input int cell_log2);
        logic [31:0] mask;
        mask = (32'd1 << cell_log2) - 32'd1;
        return ((h & mask) == 32'd0) || ((h & mask) == mask) ||
               ((v & mask) == 32'd0) || ((v & mask) == mask);
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Frame-counting blink generator for the edit cursor; forced visible while
// not editing so the cursor appears the moment editing starts.
module blink_timer
    import display_pkg::*;
#(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst_n,
    input  logic editing,
    input  logic frame_start,
    output logic blink_on
);

    localparam int             CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blink_q, blink_d;

    always_comb begin
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (!editing) begin
            cnt_d   = '0;
            blink_d = 1'b1;
        end else if (frame_start) begin
            if (cnt_q == LAST) begin
                cnt_d   = '0;
                blink_d = ~blink_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            blink_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    assign blink_on = blink_q;

endmodule

// File: rtl/pixel_compositor.sv
// Pipelined pixel colour generator: aligns scan position with the delayed
// glyph/canvas sources, then picks mouse/cursor/grid/word/background colour.
module pixel_compositor
    import display_pkg::*;
#(
    parameter int CELL_LOG2    = 5,
    parameter int H_W          = 10,
    parameter int V_W          = 9,
    parameter int COLOR_W      = 12,
    parameter int SRC_LAT      = 1,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid,
    input  logic [H_W-1:0]           h_cnt,
    input  logic [V_W-1:0]           v_cnt,
    input  logic                     frame_start,
    input  logic                     enable_mouse_display,
    input  logic [COLOR_W-1:0]       mouse_pixel,
    input  logic                     enable_word_display,
    input  logic                     editing,
    input  logic [H_W-CELL_LOG2-1:0] cursor_x,
    input  logic [V_W-CELL_LOG2-1:0] cursor_y,
    input  logic                     word_pixel,
    input  logic                     canvas_pixel,
    input  logic                     pal_we,
    input  logic [1:0]               pal_idx,
    input  logic [COLOR_W-1:0]       pal_data,
    output logic [COLOR_W-1:0]       pixel_color,
    output logic                     pixel_valid
);

    localparam int CX_W = H_W - CELL_LOG2;
    localparam int CY_W = V_W - CELL_LOG2;

    localparam logic [COLOR_W-1:0] DEF_BG  = COLOR_W'(default_color(COLOR_W, PAL_BG));
    localparam logic [COLOR_W-1:0] DEF_GR  = COLOR_W'(default_color(COLOR_W, PAL_GRID));
    localparam logic [COLOR_W-1:0] DEF_FG  = COLOR_W'(default_color(COLOR_W, PAL_FG));
    localparam logic [COLOR_W-1:0] DEF_CUR = COLOR_W'(default_color(COLOR_W, PAL_CURSOR));
    localparam logic [PAL_N-1:0][COLOR_W-1:0] PAL_RST = {DEF_CUR, DEF_FG, DEF_GR, DEF_BG};

    typedef struct packed {
        logic [H_W-1:0]     h;
        logic [V_W-1:0]     v;
        logic               mouse_en;
        logic [COLOR_W-1:0] mouse_pix;
        logic               word_en;
        logic               editing;
        logic [CX_W-1:0]    cx;
        logic [CY_W-1:0]    cy;
    } src_t;

    // vld_pipe_q[k] is valid delayed k+1 cycles; the top bit is pixel_valid.
    logic [SRC_LAT:0]   vld_pipe_q, vld_pipe_d;
    src_t [SRC_LAT-1:0] dly_q, dly_d;

    logic [PAL_N-1:0][COLOR_W-1:0] shadow_q, shadow_d;
    logic [PAL_N-1:0][COLOR_W-1:0] active_q, active_d;
    logic [COLOR_W-1:0]            color_q, color_d;
    logic                          blink_on;

    src_t a;
    logic a_vld;
    logic border;
    logic in_cursor;

    blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk        (clk),
        .rst_n      (rst_n),
        .editing    (editing),
        .frame_start(frame_start),
        .blink_on   (blink_on)
    );

    // Stage A: source-latency alignment
    always_comb begin
        vld_pipe_d        = {vld_pipe_q[SRC_LAT-1:0], valid};
        dly_d             = dly_q;
        dly_d[0].h         = h_cnt;
        dly_d[0].v         = v_cnt;
        dly_d[0].mouse_en  = enable_mouse_display;
        dly_d[0].mouse_pix = mouse_pixel;
        dly_d[0].word_en   = enable_word_display;
        dly_d[0].editing   = editing;
        dly_d[0].cx        = cursor_x;
        dly_d[0].cy        = cursor_y;
        for (int i = 1; i < SRC_LAT; i++) dly_d[i] = dly_q[i-1];
    end

    // The commit reads the registered shadow, so a coincident write waits a frame.
    always_comb begin
        shadow_d = shadow_q;
        if (pal_we) shadow_d[pal_idx] = pal_data;
        active_d = frame_start ? shadow_q : active_q;
    end

    // Stage B: colour priority
    always_comb begin
        a         = dly_q[SRC_LAT-1];
        a_vld     = vld_pipe_q[SRC_LAT-1];
        border    = is_border(32'(a.h), 32'(a.v), CELL_LOG2);
        in_cursor = a.editing && blink_on &&
                    (a.h[H_W-1:CELL_LOG2] == a.cx) &&
                    (a.v[V_W-1:CELL_LOG2] == a.cy);
        color_d   = '0;
        if (!a_vld)
            color_d = '0;
        else if (a.mouse_en)
            color_d = a.mouse_pix;
        else if (in_cursor && border)
            color_d = canvas_pixel ? active_q[PAL_CURSOR] : active_q[PAL_GRID];
        else if (in_cursor)
            color_d = canvas_pixel ? active_q[PAL_FG] : active_q[PAL_BG];
        else if (border)
            color_d = active_q[PAL_GRID];
        else if (a.word_en && word_pixel)
            color_d = active_q[PAL_FG];
        else
            color_d = active_q[PAL_BG];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            dly_q      <= '0;
            shadow_q   <= PAL_RST;
            active_q   <= PAL_RST;
            color_q    <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            dly_q      <= dly_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            color_q    <= color_d;
        end
    end

    assign pixel_color = color_q;
    assign pixel_valid = vld_pipe_q[SRC_LAT];

endmodule

// File: tb/tb_pixel_compositor.sv
// Bench for pixel_compositor: directed table, hand sequences for palette,
// blink and reset, then random pixels scored against a reference model.
module tb_pixel_compositor;

    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [9:0]  h_cnt = '0;
    logic [8:0]  v_cnt = '0;
    logic        frame_start = 1'b0;
    logic        enable_mouse_display = 1'b0;
    logic [11:0] mouse_pixel = '0;
    logic        enable_word_display = 1'b0;
    logic        editing = 1'b0;
    logic [4:0]  cursor_x = '0;
    logic [3:0]  cursor_y = '0;
    logic        word_pixel = 1'b0;
    logic        canvas_pixel = 1'b0;
    logic        pal_we = 1'b0;
    logic [1:0]  pal_idx = '0;
    logic [11:0] pal_data = '0;
    logic [11:0] pixel_color;
    logic        pixel_valid;

    pixel_compositor #(
        .CELL_LOG2(5), .H_W(10), .V_W(9), .COLOR_W(12), .SRC_LAT(1), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .frame_start(frame_start), .enable_mouse_display(enable_mouse_display),
        .mouse_pixel(mouse_pixel), .enable_word_display(enable_word_display),
        .editing(editing), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .word_pixel(word_pixel), .canvas_pixel(canvas_pixel), .pal_we(pal_we),
        .pal_idx(pal_idx), .pal_data(pal_data), .pixel_color(pixel_color),
        .pixel_valid(pixel_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [9:0]  h;
        logic [8:0]  v;
        logic        fs;
        logic        mouse_en;
        logic [11:0] mouse_pix;
        logic        word_en;
        logic        editing;
        logic [4:0]  cx;
        logic [3:0]  cy;
        logic        word;
        logic        canvas;
        logic        we;
        logic [1:0]  idx;
        logic [11:0] data;
    } pix_t;

    typedef struct { pix_t p; logic [11:0] exp; } vec_t;
    typedef struct { logic vld; logic [11:0] col; } exp_t;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t expq[$];
    pix_t prev;

    // Reference model state
    logic [11:0] m_active [4];
    logic [11:0] m_shadow [4];
    int          m_cnt;
    bit          m_blink;

    function automatic pix_t px(input logic vl, input int h, input int v,
                                input logic wen, input logic w, input logic ed,
                                input int cx, input int cy, input logic cv,
                                input logic men, input logic [11:0] mp);
        pix_t r;
        r.valid = vl; r.h = 10'(h); r.v = 9'(v); r.fs = 1'b0;
        r.mouse_en = men; r.mouse_pix = mp; r.word_en = wen; r.editing = ed;
        r.cx = 5'(cx); r.cy = 4'(cy); r.word = w; r.canvas = cv;
        r.we = 1'b0; r.idx = 2'd0; r.data = 12'h000;
        return r;
    endfunction

    task automatic model_reset();
        m_active = '{12'h000, 12'h333, 12'hfff, 12'hccc};
        m_shadow = '{12'h000, 12'h333, 12'hfff, 12'hccc};
        m_cnt    = 0;
        m_blink  = 1'b1;
    endtask

    task automatic model_step(input pix_t p, output logic [11:0] c);
        int  hx, vy;
        bit  bord, cur;
        if (!p.editing) begin
            m_cnt = 0; m_blink = 1'b1;
        end else if (p.fs) begin
            if (m_cnt == BF - 1) begin m_cnt = 0; m_blink = !m_blink; end
            else m_cnt = m_cnt + 1;
        end
        if (p.fs) m_active = m_shadow;
        if (p.we) m_shadow[p.idx] = p.data;
        hx   = int'(p.h) % 32;
        vy   = int'(p.v) % 32;
        bord = (hx == 0) || (hx == 31) || (vy == 0) || (vy == 31);
        cur  = p.editing && m_blink && (int'(p.h) / 32 == int'(p.cx)) &&
               (int'(p.v) / 32 == int'(p.cy));
        if (!p.valid)                c = 12'h000;
        else if (p.mouse_en)         c = p.mouse_pix;
        else if (cur && bord)        c = p.canvas ? m_active[3] : m_active[1];
        else if (cur)                c = p.canvas ? m_active[2] : m_active[0];
        else if (bord)               c = m_active[1];
        else if (p.word_en && p.word) c = m_active[2];
        else                         c = m_active[0];
    endtask

    // One pixel per call; entered and left just after a rising edge.
    task automatic step(input pix_t p, input bit use_tbl, input logic [11:0] tbl_c);
        logic [11:0] mc;
        exp_t        e;
        valid = p.valid; h_cnt = p.h; v_cnt = p.v; frame_start = p.fs;
        enable_mouse_display = p.mouse_en; mouse_pixel = p.mouse_pix;
        enable_word_display = p.word_en; editing = p.editing;
        cursor_x = p.cx; cursor_y = p.cy;
        pal_we = p.we; pal_idx = p.idx; pal_data = p.data;
        word_pixel = prev.word; canvas_pixel = prev.canvas;
        model_step(p, mc);
        prev = p;
        @(negedge clk);
        e.vld = p.valid;
        e.col = use_tbl ? tbl_c : mc;
        expq.push_back(e);
        if (expq.size() > 2) begin
            e = expq.pop_front();
            n_vec++;
            if (pixel_valid !== e.vld || pixel_color !== e.col) begin
                n_bad++;
                $display("FAIL vec%0d: valid/color got %b/%h expected %b/%h",
                         n_vec, pixel_valid, pixel_color, e.vld, e.col);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        exp_t z;
        valid = 1'b0; frame_start = 1'b0; pal_we = 1'b0; editing = 1'b0;
        enable_mouse_display = 1'b0; enable_word_display = 1'b0;
        word_pixel = 1'b0; canvas_pixel = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        prev = px(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000);
        expq.delete();
        z.vld = 1'b0; z.col = 12'h000;
        expq.push_back(z);
        expq.push_back(z);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [15];
    pix_t p;

    initial begin
        tbl[0]  = '{px(1,  0,  5, 0, 0, 0, 0, 0, 0, 0, 12'h000), 12'h333};
        tbl[1]  = '{px(1,  5,  5, 1, 0, 0, 0, 0, 0, 0, 12'h000), 12'h000};
        tbl[2]  = '{px(1,  6,  5, 1, 1, 0, 0, 0, 0, 0, 12'h000), 12'hfff};
        tbl[3]  = '{px(1, 31,  5, 0, 0, 0, 0, 0, 0, 0, 12'h000), 12'h333};
        tbl[4]  = '{px(1, 40, 31, 0, 0, 0, 0, 0, 0, 0, 12'h000), 12'h333};
        tbl[5]  = '{px(1, 40, 40, 0, 0, 1, 1, 1, 0, 1, 12'hf00), 12'hf00};
        tbl[6]  = '{px(0, 40, 40, 0, 0, 1, 1, 1, 0, 1, 12'hf00), 12'h000};
        tbl[7]  = '{px(1, 64, 32, 0, 0, 1, 2, 1, 1, 0, 12'h000), 12'hccc};
        tbl[8]  = '{px(1, 70, 40, 0, 0, 1, 2, 1, 1, 0, 12'h000), 12'hfff};
        tbl[9]  = '{px(1, 64, 32, 0, 0, 1, 2, 1, 0, 0, 12'h000), 12'h333};
        tbl[10] = '{px(1, 70, 40, 0, 0, 1, 2, 1, 0, 0, 12'h000), 12'h000};
        tbl[11] = '{px(1, 70, 40, 0, 0, 0, 2, 1, 1, 0, 12'h000), 12'h000};
        tbl[12] = '{px(1, 95, 63, 0, 0, 1, 2, 1, 1, 0, 12'h000), 12'hccc};
        tbl[13] = '{px(1, 96, 40, 0, 0, 1, 2, 1, 1, 0, 12'h000), 12'h333};
        tbl[14] = '{px(1, 10, 10, 0, 1, 0, 0, 0, 0, 0, 12'h000), 12'h000};

        do_reset();
        for (int i = 0; i < 15; i++) step(tbl[i].p, 1'b1, tbl[i].exp);

        // Palette: mid-frame write, coincident write, last write wins
        p = px(1, 10, 10, 1, 1, 0, 0, 0, 0, 0, 12'h000);
        p.we = 1'b1; p.idx = 2'd2; p.data = 12'h0f0; step(p, 1'b1, 12'hfff);
        p.we = 1'b0;                                 step(p, 1'b1, 12'hfff);
        p.fs = 1'b1;                                 step(p, 1'b1, 12'h0f0);
        p.we = 1'b1; p.data = 12'h00f;               step(p, 1'b1, 12'h0f0);
        p.fs = 1'b0; p.we = 1'b0;                    step(p, 1'b1, 12'h0f0);
        p.fs = 1'b1;                                 step(p, 1'b1, 12'h00f);
        p = px(1, 10, 10, 1, 0, 0, 0, 0, 0, 0, 12'h000);
        p.we = 1'b1; p.idx = 2'd0; p.data = 12'h111; step(p, 1'b1, 12'h000);
        p.data = 12'h222;                            step(p, 1'b1, 12'h000);
        p.we = 1'b0; p.fs = 1'b1;                    step(p, 1'b1, 12'h222);

        // Blink with BLINK_FRAMES=2: fg=00f marks visible, bg=222 hidden
        p = px(1, 40, 40, 0, 0, 0, 1, 1, 1, 0, 12'h000); step(p, 1'b1, 12'h222);
        p.editing = 1'b1;                               step(p, 1'b1, 12'h00f);
        p.fs = 1'b1; step(p, 1'b1, 12'h00f);
        p.fs = 1'b0; step(p, 1'b1, 12'h00f);
        p.fs = 1'b1; step(p, 1'b1, 12'h222);
        p.fs = 1'b0; step(p, 1'b1, 12'h222);
        p.fs = 1'b1; step(p, 1'b1, 12'h222);
        step(p, 1'b1, 12'h00f);
        step(p, 1'b1, 12'h00f);
        step(p, 1'b1, 12'h222);
        p.fs = 1'b0; p.editing = 1'b0; step(p, 1'b1, 12'h222);
        p.editing = 1'b1;              step(p, 1'b1, 12'h00f);

        // Reset mid-line after a grid colour commit
        p = px(1, 0, 10, 0, 0, 0, 0, 0, 0, 0, 12'h000);
        p.we = 1'b1; p.idx = 2'd1; p.data = 12'h0aa; step(p, 1'b1, 12'h333);
        p.we = 1'b0; p.fs = 1'b1;                    step(p, 1'b1, 12'h0aa);
        p.fs = 1'b0;                                 step(p, 1'b1, 12'h0aa);
        step(p, 1'b1, 12'h0aa);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (pixel_color !== 12'h000 || pixel_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: valid/color got %b/%h expected 0/000",
                     pixel_valid, pixel_color);
        end
        do_reset();
        step(p, 1'b1, 12'h333);
        step(p, 1'b1, 12'h333);

        // Random pixels against the model
        for (int i = 0; i < 500; i++) begin
            p = px(($urandom_range(0, 9) != 0), $urandom_range(0, 127),
                   $urandom_range(0, 127), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) != 0), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'($urandom),
                   ($urandom_range(0, 7) == 0), 12'($urandom));
            p.fs   = ($urandom_range(0, 9) == 0);
            p.we   = ($urandom_range(0, 5) == 0);
            p.idx  = 2'($urandom);
            p.data = 12'($urandom);
            step(p, 1'b0, 12'h000);
        end

        p = px(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000);
        repeat (3) step(p, 1'b0, 12'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
